load_extend_ctrl: RTL

Sequencer for sub-word loads. It accepts a load request (byte, halfword or word; signed or unsigned) from the core, runs a word-aligned read handshake on the data memory port, and selects the addressed byte or halfword lane. It then zero- or sign-extends the lane to 32 bits and returns the result through a valid/ready response channel. It sits between the core's load path and the data memory, replacing the fixed 8-to-32 zero-extend wiring with a controlled, error-checked, multi-cycle path.

---
 rtl/load_extend_ctrl_pkg.sv | 39 +++
 rtl/load_extend_ctrl_if.sv | 30 +++
 rtl/load_extend_ctrl_lane_extend.sv | 43 ++++
 rtl/load_extend_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/load_extend_ctrl_pkg.sv
// Shared definitions for the sub-word load sequencer: load-type codes,
// FSM state enum, wait-counter width and request legality helpers.
// Optional feature macro: LOAD_SIGNED_EN (makes LB/LH legal).
package load_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the load type code is implemented in this build.
  function automatic logic type_legal(input logic [2:0] ltype);
    logic ok;
    ok = (ltype == LW) || (ltype == LBU) || (ltype == LHU);
`ifdef LOAD_SIGNED_EN
    ok = ok || (ltype == LB) || (ltype == LH);
`endif
    return ok;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned address.
  function automatic logic misaligned(input logic [2:0] ltype, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    if ((ltype == LH) || (ltype == LHU)) bad = lane[0];
    if (ltype == LW) bad = (lane != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/load_extend_ctrl_if.sv
// Bundle of the request, data-memory and response channels of the load
// sequencer. slave is the controller's view, master the environment's.
interface load_extend_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;

  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_addr, req_type, mem_ack, mem_rdata, rsp_ready,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_type, mem_ack, mem_rdata, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/load_extend_ctrl_lane_extend.sv
// Combinational lane select and zero/sign extension of a little-endian
// read word. Sign-extending types exist only when LOAD_SIGNED_EN is defined.
module lane_extend
  import load_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  ltype,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword lanes.
  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  // Widen the selected lane according to the load type.
  always_comb begin
    ext = '0;
    case (ltype)
      LBU: ext = {24'd0, byte_sel};
      LHU: ext = {16'd0, half_sel};
      LW:  ext = rdata;
`ifdef LOAD_SIGNED_EN
      LB:  ext = {{24{byte_sel[7]}}, byte_sel};
      LH:  ext = {{16{half_sel[15]}}, half_sel};
`endif
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/load_extend_ctrl.sv
// Sub-word load sequencer: accepts a load request, performs one aligned
// read on the data memory port with a wait timeout, extends the addressed
// lane and returns it on a valid/ready response channel.
// Optional feature macro: LOAD_SIGNED_EN (signed LB/LH loads).
//
// state | meaning
// IDLE  | ready for a request; checks legality and alignment on accept
// MEM   | read request held on the memory port, waiting for mem_ack
// RESP  | response held on rsp_* until the consumer takes it
module load_extend_ctrl
  import load_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst_n,
  load_extend_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [2:0]       type_q, type_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_en_q, rd_en_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [31:0]      ext_val;

  lane_extend u_lane_extend (
    .rdata (bus.mem_rdata),
    .lane  (lane_q),
    .ltype (type_q),
    .ext   (ext_val)
  );

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    lane_d      = lane_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rd_en_d     = rd_en_q;
    rsp_valid_d = rsp_valid_q;
    data_d      = data_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          type_d = bus.req_type;
          lane_d = bus.req_addr[1:0];
          addr_d = {bus.req_addr[31:2], 2'b00};
          if (!type_legal(bus.req_type) || misaligned(bus.req_type, bus.req_addr[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            data_d      = '0;
            err_d       = 1'b1;
          end else begin
            state_d = MEM;
            rd_en_d = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      MEM: begin
        // An ack on the final wait cycle still delivers data.
        if (bus.mem_ack) begin
          state_d     = RESP;
          rd_en_d     = 1'b0;
          rsp_valid_d = 1'b1;
          data_d      = ext_val;
          err_d       = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          rd_en_d     = 1'b0;
          rsp_valid_d = 1'b1;
          data_d      = '0;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rd_en_d     = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      type_q      <= '0;
      lane_q      <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      lane_q      <= lane_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      rsp_valid_q <= rsp_valid_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;

endmodule
